fifo_ptr_ctrl: RTL and testbench
================================

# fifo_ptr_ctrl

Sequential companion to the 8-entry FIFO next-state decoder. It registers the 3-bit FIFO state from the decoder's `next_state`, maintains head/tail pointers and the occupancy count (`data_count`, fed back to the decoder), and drives register-file write/read strobes and addresses. It also drives the registered status flags. It sits directly downstream of the next-state logic and upstream of the 8×32 register file and output stage.

## Interface
- `AW`, default 3: pointer width; depth = 2^AW = 8. Count width is AW+1.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `next_state` input, 3 bits: state from the next-state decoder. Encodings: INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101.
- `state` output, 3 bits: registered current state.
- `data_count` output, AW+1 bits: registered occupancy, 0..8.
- `head` output, AW bits: registered read pointer.
- `tail` output, AW bits: registered write pointer.
- `we` output, 1 bit: register-file write strobe, combinational.
- `re` output, 1 bit: register-file read strobe, combinational.
- `wr_addr` output, AW bits: equals `tail`.
- `rd_addr` output, AW bits: equals `head`.
- `full`, `empty` outputs, 1 bit each: registered status flags.
- `wr_ack`, `wr_err`, `rd_ack`, `rd_err` outputs, 1 bit each: registered handshake flags.

## Operation
- Reset (async, any time): `state`=INIT, `head`=0, `tail`=0, `data_count`=0, `empty`=1, `full`=0, all ack/err=0. `we`/`re` become 0 immediately, because `next_state` decode is masked while `reset`=1.
- Effective state `eff` is derived from `next_state`, with the guard described under Configuration.
- `we` = (`eff`==WRITE). `re` = (`eff`==READ). Both are combinational, so the register file acts on the same edge that commits the state.
- At each rising edge, `state`<=`eff`, then:
  - WRITE: `tail`<=`tail`+1 (mod 8), `data_count`+=1.
  - READ: `head`<=`head`+1 (mod 8), `data_count`-=1.
  - INIT, NO_OP, WR_ERROR, RD_ERROR: pointers and count hold.
  - Undefined codes 110/111: treated as NO_OP; `state` is loaded with NO_OP.
- Pointer wrap: 7+1 -> 0. `data_count` never wraps; the range 0..8 is guaranteed by the guard.
- Flags are computed from post-edge values:
  - `full` = (`data_count`==8); `empty` = (`data_count`==0).
  - `wr_ack` = (`state`==WRITE); `wr_err` = (`state`==WR_ERROR).
  - `rd_ack` = (`state`==READ); `rd_err` = (`state`==RD_ERROR).
  - At most one ack/err flag is high in any cycle.
- `head`==`tail` is ambiguous (empty or full). `data_count` alone resolves it.

## Timing
- `next_state` to `we`/`re`: combinational, same cycle.
- Commit to `state`, `head`, `tail`, `data_count` and flags: one edge after `next_state` is presented.
- A `data_count` update is visible to the decoder in the cycle following the operation. The decoder/ctrl loop therefore supports back-to-back operations, one per cycle.
- Reset mid-operation: an asserted `we` is withdrawn asynchronously, and no partial pointer update occurs.
- Reset release: the first edge with `reset`=0 samples `next_state` normally.

## Configuration
- `FIFO_GUARD_EN` defined:
  - `next_state`==WRITE with `data_count`==8 is demoted to WR_ERROR: no write, no pointer move.
  - `next_state`==READ with `data_count`==0 is demoted to RD_ERROR.
- `FIFO_GUARD_EN` undefined:
  - `eff`=`next_state` (undefined codes are still mapped to NO_OP).
  - The block trusts the decoder completely. An illegal WRITE at full moves `tail` and sets `data_count` to 9. The guard logic is absent from the netlist.

## Test plan
- Reset: assert `reset` mid-cycle while `next_state`=WRITE. Required: `we`=0 immediately; `state`=000, `head`=`tail`=0, `data_count`=0, `empty`=1 with no clock edge.
- Fill: 8 cycles of WRITE from empty. Required: `wr_addr` sequence 0..7; `we`=1 each cycle; `wr_ack`=1; final `tail`=0, `data_count`=8, `full`=1, `empty`=0.
- Overflow, with `FIFO_GUARD_EN`: WRITE presented at count 8. Required: `we`=0, `state`=011, `wr_err`=1, `data_count` stays 8, `tail` stays 0.
- Drain and underflow: 8 READs from full, then a 9th READ. Required:
  - `rd_addr` sequence 0..7; `data_count` 7..0; `empty`=1 after the 8th READ.
  - The 9th READ gives `state`=101, `rd_err`=1, `re`=0 (with guard).
- Wrap-around: 5 WRITEs, 5 READs, 6 WRITEs. Required: final `tail`=3 (5+6=11 mod 8), `head`=5, `data_count`=6, `full`=0.
- Undefined code: `next_state`=111 at count 3. Required: `state`=001, pointers and count unchanged, all ack/err=0.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// Sequential pointer/count/flag controller for the 8-entry FIFO, fed by the next-state decoder.
// Optional FIFO_GUARD_EN demotes WRITE-at-full / READ-at-empty to the matching error state.
module fifo_ptr_ctrl #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    next_state,
  output logic [2:0]    state,
  output logic [AW:0]   data_count,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic          we,
  output logic          re,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101
  } state_t;

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  state_t        state_q, eff;
  logic [AW-1:0] head_q, tail_q, head_nxt, tail_nxt;
  logic [AW:0]   count_q, count_nxt;

  // Decode is masked during reset so strobes drop without waiting for an edge.
  always_comb begin
    eff = NO_OP;
    if (reset) begin
      eff = INIT;
    end else begin
      case (next_state)
        INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR: eff = state_t'(next_state);
        default:                                      eff = NO_OP;
      endcase
`ifdef FIFO_GUARD_EN
      if (eff == WRITE && count_q == FULL_CNT) eff = WR_ERROR;
      if (eff == READ && count_q == '0)        eff = RD_ERROR;
`endif
    end
  end

  always_comb begin
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    count_nxt = count_q;
    case (eff)
      WRITE: begin
        tail_nxt  = tail_q + AW'(1);
        count_nxt = count_q + (AW+1)'(1);
      end
      READ: begin
        head_nxt  = head_q + AW'(1);
        count_nxt = count_q - (AW+1)'(1);
      end
      default: ;
    endcase
  end

  // Flags are registered from the post-edge values so they line up with state/count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      state_q <= eff;
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      count_q <= count_nxt;
      full    <= (count_nxt == FULL_CNT);
      empty   <= (count_nxt == '0);
      wr_ack  <= (eff == WRITE);
      wr_err  <= (eff == WR_ERROR);
      rd_ack  <= (eff == READ);
      rd_err  <= (eff == RD_ERROR);
    end
  end

  assign state      = state_q;
  assign head       = head_q;
  assign tail       = tail_q;
  assign data_count = count_q;
  assign wr_addr    = tail_q;
  assign rd_addr    = head_q;
  assign we         = (eff == WRITE);
  assign re         = (eff == READ);

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: directed scenarios plus random traffic
// against an integer occupancy/pointer model of the FIFO.
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] next_state = 3'b000;
  logic [2:0] state;
  logic [3:0] data_count;
  logic [2:0] head, tail, wr_addr, rd_addr;
  logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;

  int total = 0;
  int bad = 0;

  // Reference model: plain integers, modulo-8 pointers.
  int       m_count = 0;
  int       m_head = 0;
  int       m_tail = 0;
  int       m_state = 0;

  fifo_ptr_ctrl #(.AW(3)) dut (
    .clk(clk), .reset(reset), .next_state(next_state), .state(state),
    .data_count(data_count), .head(head), .tail(tail), .we(we), .re(re),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .full(full), .empty(empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  function automatic int model_eff(input int ns);
    int e;
    e = (ns > 5) ? 1 : ns;
`ifdef FIFO_GUARD_EN
    if (e == 2 && m_count == 8) e = 3;
    if (e == 4 && m_count == 0) e = 5;
`endif
    return e;
  endfunction

  task automatic model_reset();
    m_count = 0; m_head = 0; m_tail = 0; m_state = 0;
  endtask

  task automatic set_ns(input logic [2:0] ns);
    @(negedge clk);
    next_state = ns;
    #1;
  endtask

  task automatic commit();
    int e;
    @(posedge clk);
    e = model_eff(int'(next_state));
    m_state = e;
    if (e == 2) begin m_tail = (m_tail + 1) % 8; m_count++; end
    if (e == 4) begin m_head = (m_head + 1) % 8; m_count--; end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (state !== 3'd0 || head !== 3'd0 || tail !== 3'd0 || data_count !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_regs state=%0d head=%0d tail=%0d count=%0d exp all 0", state, head, tail, data_count); end
    total++; if (empty !== 1'b1 || full !== 1'b0 || {wr_ack, wr_err, rd_ack, rd_err} !== 4'b0) begin
      bad++; $display("[TB] FAIL reset_flags empty=%b full=%b acks=%b exp empty=1 full=0 acks=0000", empty, full, {wr_ack, wr_err, rd_ack, rd_err}); end
    @(negedge clk); reset = 1'b0;
    model_reset();
    repeat (2) begin set_ns(3'b010); commit(); end
    // Reset arrives mid-cycle with WRITE presented, well before the next edge.
    set_ns(3'b010);
    total++; if (we !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_we got=%b exp=1", we); end
    #1 reset = 1'b1;
    #1;
    total++; if (we !== 1'b0 || re !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_we we=%b re=%b exp 0 0", we, re); end
    total++; if (state !== 3'd0 || head !== 3'd0 || tail !== 3'd0 || data_count !== 4'd0 || empty !== 1'b1) begin
      bad++; $display("[TB] FAIL async_reset_regs state=%0d head=%0d tail=%0d count=%0d empty=%b exp 0 0 0 0 1", state, head, tail, data_count, empty); end
    model_reset();
    @(negedge clk); next_state = 3'b001; reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      set_ns(3'b010);
      total++; if (we !== 1'b1 || wr_addr !== 3'(i)) begin
        bad++; $display("[TB] FAIL fill_we_addr i=%0d we=%b wr_addr=%0d exp we=1 addr=%0d", i, we, wr_addr, i); end
      commit();
      total++; if (wr_ack !== 1'b1 || data_count !== 4'(i + 1)) begin
        bad++; $display("[TB] FAIL fill_ack_count i=%0d wr_ack=%b count=%0d exp 1 %0d", i, wr_ack, data_count, i + 1); end
    end
    total++; if (tail !== 3'd0 || data_count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
      bad++; $display("[TB] FAIL fill_final tail=%0d count=%0d full=%b empty=%b exp 0 8 1 0", tail, data_count, full, empty); end
  endtask

  task automatic test_overflow();
`ifdef FIFO_GUARD_EN
    set_ns(3'b010);
    total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL overflow_we got=%b exp=0", we); end
    commit();
    total++; if (state !== 3'b011 || wr_err !== 1'b1 || wr_ack !== 1'b0 || data_count !== 4'd8 || tail !== 3'd0) begin
      bad++; $display("[TB] FAIL overflow_regs state=%0d wr_err=%b wr_ack=%b count=%0d tail=%0d exp 3 1 0 8 0", state, wr_err, wr_ack, data_count, tail); end
`else
    set_ns(3'b001);
    commit();
    total++; if (state !== 3'b001 || {wr_ack, wr_err, rd_ack, rd_err} !== 4'b0 || data_count !== 4'd8 || full !== 1'b1) begin
      bad++; $display("[TB] FAIL hold_at_full state=%0d acks=%b count=%0d full=%b exp 1 0000 8 1", state, {wr_ack, wr_err, rd_ack, rd_err}, data_count, full); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      set_ns(3'b100);
      total++; if (re !== 1'b1 || rd_addr !== 3'(i)) begin
        bad++; $display("[TB] FAIL drain_re_addr i=%0d re=%b rd_addr=%0d exp re=1 addr=%0d", i, re, rd_addr, i); end
      commit();
      total++; if (rd_ack !== 1'b1 || data_count !== 4'(7 - i)) begin
        bad++; $display("[TB] FAIL drain_ack_count i=%0d rd_ack=%b count=%0d exp 1 %0d", i, rd_ack, data_count, 7 - i); end
    end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("[TB] FAIL drain_empty empty=%b full=%b exp 1 0", empty, full); end
`ifdef FIFO_GUARD_EN
    set_ns(3'b100);
    total++; if (re !== 1'b0) begin bad++; $display("[TB] FAIL underflow_re got=%b exp=0", re); end
    commit();
    total++; if (state !== 3'b101 || rd_err !== 1'b1 || data_count !== 4'd0 || head !== 3'd0) begin
      bad++; $display("[TB] FAIL underflow_regs state=%0d rd_err=%b count=%0d head=%0d exp 5 1 0 0", state, rd_err, data_count, head); end
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      set_ns((i >= 5 && i < 10) ? 3'b100 : 3'b010);
      commit();
    end
    total++; if (tail !== 3'd3 || head !== 3'd5 || data_count !== 4'd6 || full !== 1'b0) begin
      bad++; $display("[TB] FAIL wrap_final tail=%0d head=%0d count=%0d full=%b exp 3 5 6 0", tail, head, data_count, full); end
  endtask

  task automatic test_undefined();
    repeat (3) begin set_ns(3'b100); commit(); end
    set_ns(3'b111);
    total++; if (we !== 1'b0 || re !== 1'b0) begin bad++; $display("[TB] FAIL undef_strobes we=%b re=%b exp 0 0", we, re); end
    commit();
    total++; if (state !== 3'b001 || head !== 3'd0 || tail !== 3'd3 || data_count !== 4'd3 || {wr_ack, wr_err, rd_ack, rd_err} !== 4'b0) begin
      bad++; $display("[TB] FAIL undef_regs state=%0d head=%0d tail=%0d count=%0d acks=%b exp 1 0 3 3 0000", state, head, tail, data_count, {wr_ack, wr_err, rd_ack, rd_err}); end
  endtask

  task automatic test_random();
    logic [2:0] ns;
    int         e;
    for (int i = 0; i < 300; i++) begin
      ns = 3'($urandom_range(0, 7));
`ifndef FIFO_GUARD_EN
      if (ns == 3'b010 && m_count == 8) ns = 3'b001;
      if (ns == 3'b100 && m_count == 0) ns = 3'b001;
`endif
      set_ns(ns);
      e = model_eff(int'(ns));
      total++; if (we !== (e == 2) || re !== (e == 4) || wr_addr !== 3'(m_tail) || rd_addr !== 3'(m_head)) begin
        bad++; $display("[TB] FAIL rand_comb i=%0d ns=%0d we=%b re=%b wa=%0d ra=%0d exp %b %b %0d %0d", i, ns, we, re, wr_addr, rd_addr, e == 2, e == 4, m_tail, m_head); end
      commit();
      total++; if (state !== 3'(m_state) || data_count !== 4'(m_count) || head !== 3'(m_head) || tail !== 3'(m_tail)) begin
        bad++; $display("[TB] FAIL rand_regs i=%0d state=%0d count=%0d head=%0d tail=%0d exp %0d %0d %0d %0d", i, state, data_count, head, tail, m_state, m_count, m_head, m_tail); end
      total++; if (full !== (m_count == 8) || empty !== (m_count == 0) || wr_ack !== (m_state == 2) || wr_err !== (m_state == 3) || rd_ack !== (m_state == 4) || rd_err !== (m_state == 5)) begin
        bad++; $display("[TB] FAIL rand_flags i=%0d full=%b empty=%b acks=%b%b%b%b model_count=%0d model_state=%0d", i, full, empty, wr_ack, wr_err, rd_ack, rd_err, m_count, m_state); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_undefined();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
